// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch read port and a data read/writeback port onto one memory bus.
// Optional ARB_RR_EN: ties alternate between ports; otherwise the data port always wins.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_r_ena_in,
  input  logic [63:0] if_raddr_in,
  output logic [63:0] if_rdata_out,
  output logic        if_valid_out,
  input  logic        d_r_ena_in,
  input  logic [63:0] d_raddr_in,
  input  logic        d_w_ena_in,
  input  logic [63:0] d_waddr_in,
  input  logic [63:0] d_wdata_in,
  output logic [63:0] d_rdata_out,
  output logic        d_valid_out,
  output logic        bus_r_ena_out,
  output logic [63:0] bus_raddr_out,
  output logic        bus_w_ena_out,
  output logic [63:0] bus_waddr_out,
  output logic [63:0] bus_wdata_out,
  input  logic        bus_r_valid_in,
  input  logic [63:0] bus_rdata_in,
  input  logic        bus_w_done_in,
  output logic        stall_if_out,
  output logic        stall_d_out
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_own_d, r_rd_pend, r_w_ena, r_r_ena;
  logic [63:0] r_raddr, r_waddr, r_wdata, r_if_rdata, r_d_rdata;
  logic        w_if_req, w_d_req, w_grant_d;

  assign w_if_req = if_r_ena_in;
  assign w_d_req  = d_r_ena_in | d_w_ena_in;

`ifdef ARB_RR_EN
  // Remembers whether the last grant went to fetch; resets to fetch so data wins the first tie.
  logic r_last_if;
  assign w_grant_d = w_d_req & (~w_if_req | r_last_if);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    r_last_if <= 1'b1;
    else if (r_state == S_IDLE && (w_if_req || w_d_req)) r_last_if <= ~w_grant_d;
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_own_d    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_w_ena    <= 1'b0;
      r_r_ena    <= 1'b0;
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      // Command strobes are one-cycle pulses raised only on state entry.
      r_w_ena <= 1'b0;
      r_r_ena <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_if_req || w_d_req) begin
            r_own_d <= w_grant_d;
            if (w_grant_d) begin
              r_raddr   <= d_raddr_in;
              r_waddr   <= d_waddr_in;
              r_wdata   <= d_wdata_in;
              r_rd_pend <= d_r_ena_in;
              if (d_w_ena_in) begin
                r_state <= S_WRITE;
                r_w_ena <= 1'b1;
              end else begin
                r_state <= S_READ;
                r_r_ena <= 1'b1;
              end
            end else begin
              r_raddr   <= if_raddr_in;
              r_waddr   <= '0;
              r_wdata   <= '0;
              r_rd_pend <= 1'b1;
              r_state   <= S_READ;
              r_r_ena   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus_w_done_in) begin
            if (r_rd_pend) begin
              r_state <= S_READ;
              r_r_ena <= 1'b1;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_READ: begin
          if (bus_r_valid_in) begin
            if (r_own_d) r_d_rdata  <= bus_rdata_in;
            else         r_if_rdata <= bus_rdata_in;
            r_state <= S_RESP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_w_ena_out = r_w_ena;
  assign bus_r_ena_out = r_r_ena;
  assign bus_waddr_out = (r_state == S_WRITE) ? r_waddr : '0;
  assign bus_wdata_out = (r_state == S_WRITE) ? r_wdata : '0;
  assign bus_raddr_out = (r_state == S_READ)  ? r_raddr : '0;

  assign if_valid_out = (r_state == S_RESP) & ~r_own_d;
  assign d_valid_out  = (r_state == S_RESP) &  r_own_d;
  assign if_rdata_out = r_if_rdata;
  assign d_rdata_out  = r_d_rdata;

  assign stall_if_out = w_if_req & ~if_valid_out;
  assign stall_d_out  = w_d_req  & ~d_valid_out;
endmodule
